// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out word assembler with valid/ready output, frame-marker realignment
// and sticky overrun / framing-error flags.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     bit_valid,
  input  logic                     frame_start,
  input  logic                     out_ready,
  input  logic                     clear_flags,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] bit_count,
  output logic                     overrun,
  output logic                     frame_error
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_BIT  = CW'(1'b1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] first_bit_s;
  logic             complete_s;
  logic             drain_s;
  logic             load_s;
  logic             ovr_set_s;
  logic             ferr_set_s;

  // Bit-order dependent views of the shift register: normal shift and a fresh word seeded by one bit.
  always_comb begin
    shifted_s   = {WIDTH{1'b0}};
    first_bit_s = {WIDTH{1'b0}};
    if (MSB_FIRST) begin
      shifted_s   = {sr_q[WIDTH-2:0], serial_in};
      first_bit_s = {{(WIDTH-1){1'b0}}, serial_in};
    end else begin
      shifted_s   = {serial_in, sr_q[WIDTH-1:1]};
      first_bit_s = {serial_in, {(WIDTH-1){1'b0}}};
    end
  end

  // Next-state logic for the shifter, bit counter, output slot and sticky flags.
  always_comb begin
    complete_s = bit_valid & ~frame_start & (cnt_q == LAST_BIT);
    drain_s    = valid_q & out_ready;
    load_s     = complete_s & (~valid_q | out_ready);
    ovr_set_s  = complete_s & valid_q & ~out_ready;
    ferr_set_s = frame_start & (cnt_q != {CW{1'b0}});

    sr_d    = sr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;

    // A frame marker discards whatever partial word was being built.
    if (frame_start) begin
      if (bit_valid) begin
        sr_d  = first_bit_s;
        cnt_d = ONE_BIT;
      end else begin
        sr_d  = {WIDTH{1'b0}};
        cnt_d = {CW{1'b0}};
      end
    end else if (bit_valid) begin
      sr_d = shifted_s;
      if (complete_s) begin
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + ONE_BIT;
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end

    if (load_s) begin
      out_d   = shifted_s;
      valid_d = 1'b1;
    end else if (drain_s) begin
      out_d   = out_q;
      valid_d = 1'b0;
    end else begin
      out_d   = out_q;
      valid_d = valid_q;
    end

    // Setting wins over clearing on the same edge.
    ovr_d  = ovr_set_s  | (ovr_q  & ~clear_flags);
    ferr_d = ferr_set_s | (ferr_q & ~clear_flags);
  end

  // State registers; asynchronous reset drops any partial or held word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      out_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign parallel_out = out_q;
  assign out_valid    = valid_q;
  assign bit_count    = cnt_q;
  assign overrun      = ovr_q;
  assign frame_error  = ferr_q;

  sipo_deserializer_chk #(.WIDTH(WIDTH)) u_chk (
    .clk          (clk),
    .reset        (reset),
    .out_ready    (out_ready),
    .out_valid    (valid_q),
    .parallel_out (out_q)
  );

endmodule

// Protocol checker: a stalled output word must stay valid and unchanged.
module sipo_deserializer_chk #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  input logic             out_ready,
  input logic             out_valid,
  input logic [WIDTH-1:0] parallel_out
);

  logic             stall_q;
  logic [WIDTH-1:0] held_q;

  // Remember whether the previous edge was a stall and what word was presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 1'b0;
      held_q  <= {WIDTH{1'b0}};
    end else begin
      stall_q <= out_valid & ~out_ready;
      held_q  <= parallel_out;
    end
  end

  // Compare against the word captured at the stalled edge.
  always @(posedge clk) begin
    if (!reset && stall_q) begin
      assert (out_valid && (parallel_out == held_q))
        else $error("stalled output word changed");
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed table-driven bench for sipo_deserializer (WIDTH=8, both bit orders).
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in, bit_valid, frame_start, out_ready, clear_flags;
  logic [7:0] m_out, l_out;
  logic       m_valid, l_valid;
  logic [2:0] m_cnt, l_cnt;
  logic       m_ovr, l_ovr, m_ferr, l_ferr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       bv, si, fs, rdy, clr;
    logic [7:0] e_out;
    logic       e_v;
    logic [2:0] e_cnt;
    logic       e_ovr, e_fe;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clear_flags(clear_flags),
    .parallel_out(m_out), .out_valid(m_valid), .bit_count(m_cnt),
    .overrun(m_ovr), .frame_error(m_ferr)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clear_flags(clear_flags),
    .parallel_out(l_out), .out_valid(l_valid), .bit_count(l_cnt),
    .overrun(l_ovr), .frame_error(l_ferr)
  );

  task automatic add(input logic bv, si, fs, rdy, clr, input logic [7:0] eo,
                     input logic ev, input logic [2:0] ec, input logic eovr, efe);
    vec_t v;
    v.bv = bv; v.si = si; v.fs = fs; v.rdy = rdy; v.clr = clr;
    v.e_out = eo; v.e_v = ev; v.e_cnt = ec; v.e_ovr = eovr; v.e_fe = efe;
    tbl.push_back(v);
  endtask

  // n non-completing bits taken MSB-first from pat; outputs other than bit_count unchanged
  task automatic add_bits(input logic [7:0] pat, input int n, input logic rdy,
                          input logic [7:0] eo, input logic ev, input int c0,
                          input logic eovr, efe);
    for (int i = 0; i < n; i++)
      add(1'b1, pat[7-i], 1'b0, rdy, 1'b0, eo, ev, 3'(c0 + i + 1), eovr, efe);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic bv, si, fs, rdy, clr);
    bit_valid = bv; serial_in = si; frame_start = fs; out_ready = rdy; clear_flags = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clear_flags = 1'b0;

    // test 1: B2 with gaps, out_ready=1
    add(1,1,0,1,0, 8'h00,0,3'd1,0,0);
    add(1,0,0,1,0, 8'h00,0,3'd2,0,0);
    add(0,0,0,1,0, 8'h00,0,3'd2,0,0);
    add(0,1,0,1,0, 8'h00,0,3'd2,0,0);
    add(1,1,0,1,0, 8'h00,0,3'd3,0,0);
    add(1,1,0,1,0, 8'h00,0,3'd4,0,0);
    add(1,0,0,1,0, 8'h00,0,3'd5,0,0);
    add(0,0,0,1,0, 8'h00,0,3'd5,0,0);
    add(1,0,0,1,0, 8'h00,0,3'd6,0,0);
    add(1,1,0,1,0, 8'h00,0,3'd7,0,0);
    add(1,0,0,1,0, 8'hB2,1,3'd0,0,0);
    add(0,0,0,1,0, 8'hB2,0,3'd0,0,0);
    // test 3: A5 held, 3C dropped -> overrun; drain; clear
    add_bits(8'hA5, 7, 1'b0, 8'hB2, 1'b0, 0, 1'b0, 1'b0);
    add(1,1,0,0,0, 8'hA5,1,3'd0,0,0);
    add_bits(8'h3C, 7, 1'b0, 8'hA5, 1'b1, 0, 1'b0, 1'b0);
    add(1,0,0,0,0, 8'hA5,1,3'd0,1,0);
    add(0,0,0,1,0, 8'hA5,0,3'd0,1,0);
    add(0,0,0,0,1, 8'hA5,0,3'd0,0,0);
    // test 4: 3C completes on the edge that drains A5
    add_bits(8'hA5, 7, 1'b0, 8'hA5, 1'b0, 0, 1'b0, 1'b0);
    add(1,1,0,0,0, 8'hA5,1,3'd0,0,0);
    add_bits(8'h3C, 7, 1'b0, 8'hA5, 1'b1, 0, 1'b0, 1'b0);
    add(1,0,0,1,0, 8'h3C,1,3'd0,0,0);
    add(0,0,0,1,0, 8'h3C,0,3'd0,0,0);
    // test 5: realignment by frame_start after five bits -> B4
    add_bits(8'hC8, 5, 1'b1, 8'h3C, 1'b0, 0, 1'b0, 1'b0);
    add(1,1,1,1,0, 8'h3C,0,3'd1,0,1);
    add_bits(8'h68, 6, 1'b1, 8'h3C, 1'b0, 1, 1'b0, 1'b1);
    add(1,0,0,1,0, 8'hB4,1,3'd0,0,1);
    add(0,0,0,1,1, 8'hB4,0,3'd0,0,0);
    // frame_start without a bit; then frame_start at bit_count 0 (no error)
    add_bits(8'h80, 2, 1'b1, 8'hB4, 1'b0, 0, 1'b0, 1'b0);
    add(0,0,1,1,0, 8'hB4,0,3'd0,0,1);
    add(0,0,0,1,1, 8'hB4,0,3'd0,0,0);
    add(1,1,1,1,0, 8'hB4,0,3'd1,0,0);
    // frame_start beats completion; set beats clear_flags
    add_bits(8'h00, 6, 1'b1, 8'hB4, 1'b0, 1, 1'b0, 1'b0);
    add(1,0,1,1,1, 8'hB4,0,3'd1,0,1);
    add(0,0,0,1,1, 8'hB4,0,3'd1,0,0);

    #12;
    check("reset_state", {m_out, m_valid, m_cnt, m_ovr, m_ferr}, 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].bv, tbl[i].si, tbl[i].fs, tbl[i].rdy, tbl[i].clr);
      check($sformatf("vec%0d", i), {m_out, m_valid, m_cnt, m_ovr, m_ferr},
            {tbl[i].e_out, tbl[i].e_v, tbl[i].e_cnt, tbl[i].e_ovr, tbl[i].e_fe});
    end

    // shift register holds 0000_0000 at count 1; seven ones complete 7F, then three more bits
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_reset", {m_out, m_valid, m_cnt}, {8'h7F, 1'b1, 3'd3});

    // test 6: mid-cycle reset clears everything at once
    reset = 1'b1;
    #2;
    check("midreset_msb", {m_out, m_valid, m_cnt, m_ovr, m_ferr}, 32'h0);
    check("midreset_lsb", {l_out, l_valid, l_cnt, l_ovr, l_ferr}, 32'h0);
    #1;
    reset = 1'b0;

    // fresh word after reset, both bit orders (tests 2 and 6)
    drive(1,1,0,1,0); drive(1,0,0,1,0); drive(1,1,0,1,0); drive(1,1,0,1,0);
    drive(1,0,0,1,0); drive(1,0,0,1,0); drive(1,1,0,1,0);
    check("cnt7", {29'd0, m_cnt}, 32'd7);
    drive(1,0,0,1,0);
    check("fresh_msb", {m_out, m_valid, m_cnt}, {8'hB2, 1'b1, 3'd0});
    check("fresh_lsb", {l_out, l_valid, l_cnt}, {8'h4D, 1'b1, 3'd0});
    drive(0,0,0,1,0);
    check("drop_valid", {m_out, m_valid, l_out, l_valid}, {8'hB2, 1'b0, 8'h4D, 1'b0});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
